// File: rtl/aes_ct_capture_if.sv
// ---------------------------------------------------------------------------
// aes_ct_capture_if : ready/valid stream carrying captured ciphertext blocks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface aes_ct_capture_if #(
   parameter int DATA_W = 128
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_allones;

   modport master (
      output out_valid,
      output out_data,
      output out_allones,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_allones,
      output out_ready
   );
endinterface

`default_nettype wire

// File: rtl/aes_ct_capture.sv
// ---------------------------------------------------------------------------
// aes_ct_capture : latency-matched ciphertext capture FIFO with all-ones monitor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_ct_capture #(
   parameter int LATENCY = 20,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 8
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   input  wire logic                     clr,
   input  wire logic                     in_valid,
   input  wire logic [127:0]             aes_out,
   aes_ct_capture_if.master              out_if,
   output logic [$clog2(DEPTH):0]        fifo_level,
   output logic                          overflow,
   output logic [CNT_W-1:0]              anomaly_cnt
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [127:0] data;
      logic         allones;
   } entry_t;

   logic [LATENCY-1:0] v_q, v_d;
   logic [AW:0]        wr_cnt_q, wr_cnt_d;
   logic [AW:0]        rd_cnt_q, rd_cnt_d;
   logic               overflow_q, overflow_d;
   logic [CNT_W-1:0]   anomaly_cnt_q, anomaly_cnt_d;
   entry_t             mem_q [DEPTH];
   entry_t             mem_d [DEPTH];

   logic               capture, push, pop, empty, full, is_ones;
   logic [AW:0]        level;
   entry_t             head;

   // v[i] is high when the block presented i+1 edges ago is valid.
   generate
      if (LATENCY == 1) begin : g_vline_one
         assign v_d = in_valid;
      end else begin : g_vline_shift
         assign v_d = {v_q[LATENCY-2:0], in_valid};
      end
   endgenerate

   always_comb begin
      level   = wr_cnt_q - rd_cnt_q;
      empty   = (level == '0);
      full    = (level == (AW+1)'(DEPTH));
      capture = v_q[LATENCY-1];
      is_ones = &aes_out;
      pop     = !empty && out_if.out_ready;
      push    = capture && (!full || pop);

      wr_cnt_d      = wr_cnt_q;
      rd_cnt_d      = rd_cnt_q;
      overflow_d    = overflow_q;
      anomaly_cnt_d = anomaly_cnt_q;
      mem_d         = mem_q;

      if (clr) begin
         wr_cnt_d      = '0;
         rd_cnt_d      = '0;
         overflow_d    = 1'b0;
         anomaly_cnt_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_cnt_q[AW-1:0]] = '{data: aes_out, allones: is_ones};
            wr_cnt_d = wr_cnt_q + (AW+1)'(1);
            if (is_ones && (anomaly_cnt_q != {CNT_W{1'b1}}))
               anomaly_cnt_d = anomaly_cnt_q + CNT_W'(1);
         end
         if (pop)
            rd_cnt_d = rd_cnt_q + (AW+1)'(1);
         if (capture && !push)
            overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q           <= '0;
         wr_cnt_q      <= '0;
         rd_cnt_q      <= '0;
         overflow_q    <= 1'b0;
         anomaly_cnt_q <= '0;
         mem_q         <= '{default: '0};
      end else begin
         v_q           <= v_d;
         wr_cnt_q      <= wr_cnt_d;
         rd_cnt_q      <= rd_cnt_d;
         overflow_q    <= overflow_d;
         anomaly_cnt_q <= anomaly_cnt_d;
         mem_q         <= mem_d;
      end
   end

   // Head fields are forced to zero when empty so stale entries never leak out.
   always_comb begin
      head               = mem_q[rd_cnt_q[AW-1:0]];
      out_if.out_valid   = !empty;
      out_if.out_data    = empty ? 128'd0 : head.data;
      out_if.out_allones = !empty && head.allones;
   end

   assign fifo_level  = level;
   assign overflow    = overflow_q;
   assign anomaly_cnt = anomaly_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_ct_capture.sv
// ---------------------------------------------------------------------------
// tb_aes_ct_capture : directed self-checking bench for aes_ct_capture
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aes_ct_capture;

   localparam int LAT   = 20;
   localparam int DEPTH = 4;
   localparam int CNT_W = 2;

   localparam logic [127:0] ONES = {128{1'b1}};
   localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk;
   logic         rst;
   logic         clr;
   logic         in_valid;
   logic [127:0] aes_out;
   logic [2:0]   fifo_level;
   logic         overflow;
   logic [1:0]   anomaly_cnt;

   int n_tests;
   int n_fail;

   aes_ct_capture_if #(.DATA_W(128)) u_if ();

   aes_ct_capture #(
      .LATENCY (LAT),
      .DEPTH   (DEPTH),
      .CNT_W   (CNT_W)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .in_valid    (in_valid),
      .aes_out     (aes_out),
      .out_if      (u_if),
      .fifo_level  (fifo_level),
      .overflow    (overflow),
      .anomaly_cnt (anomaly_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // n consecutive in_valid pulses, then idle until the first capture edge is next.
   task automatic launch(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      repeat (LAT - n) tick();
   endtask

   initial begin
      n_tests         = 0;
      n_fail          = 0;
      rst             = 1'b0;
      clr             = 1'b0;
      in_valid        = 1'b0;
      aes_out         = '0;
      u_if.out_ready  = 1'b0;

      // 1: reset state and idle
      #12;
      check("rst_valid",    128'(u_if.out_valid),   128'd0);
      check("rst_data",     u_if.out_data,          128'd0);
      check("rst_allones",  128'(u_if.out_allones), 128'd0);
      check("rst_level",    128'(fifo_level),       128'd0);
      check("rst_overflow", 128'(overflow),         128'd0);
      check("rst_anomaly",  128'(anomaly_cnt),      128'd0);
      tick();
      rst = 1'b1;
      repeat (50) tick();
      check("idle_level", 128'(fifo_level),     128'd0);
      check("idle_valid", 128'(u_if.out_valid), 128'd0);

      // 2: single block, exact latency
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (LAT - 2) tick();
      check("single_early", 128'(u_if.out_valid), 128'd0);
      tick();
      aes_out = CT0;
      tick();
      aes_out = '0;
      check("single_valid",   128'(u_if.out_valid),   128'd1);
      check("single_data",    u_if.out_data,          CT0);
      check("single_level",   128'(fifo_level),       128'd1);
      check("single_allones", 128'(u_if.out_allones), 128'd0);
      u_if.out_ready = 1'b1;
      tick();
      u_if.out_ready = 1'b0;
      check("single_pop_level", 128'(fifo_level),     128'd0);
      check("single_pop_valid", 128'(u_if.out_valid), 128'd0);
      check("single_pop_data",  u_if.out_data,        128'd0);

      // 3: overflow, block 5 dropped
      launch(5);
      for (int k = 1; k <= 5; k++) begin
         aes_out = 128'(k);
         tick();
      end
      aes_out = '0;
      check("ovf_level", 128'(fifo_level), 128'd4);
      check("ovf_flag",  128'(overflow),   128'd1);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("ovf_pop%0d", k), u_if.out_data, 128'(k));
         u_if.out_ready = 1'b1;
         tick();
         u_if.out_ready = 1'b0;
      end
      check("ovf_empty",  128'(u_if.out_valid), 128'd0);
      check("ovf_sticky", 128'(overflow),       128'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("ovf_clr", 128'(overflow), 128'd0);

      // 4: all-ones anomaly counting, saturating at 3
      u_if.out_ready = 1'b1;
      launch(5);
      for (int k = 1; k <= 5; k++) begin
         aes_out = ONES;
         tick();
         check($sformatf("anom_allones%0d", k), 128'(u_if.out_allones), 128'd1);
         check($sformatf("anom_cnt%0d", k), 128'(anomaly_cnt), 128'((k > 3) ? 3 : k));
      end
      aes_out = '0;
      tick();
      check("anom_drained", 128'(fifo_level), 128'd0);
      launch(1);
      aes_out = 128'h1234;
      tick();
      aes_out = '0;
      check("anom_normal_allones", 128'(u_if.out_allones), 128'd0);
      check("anom_normal_cnt",     128'(anomaly_cnt),      128'd3);
      tick();
      u_if.out_ready = 1'b0;
      check("anom_normal_drained", 128'(fifo_level), 128'd0);

      // 5: full FIFO with simultaneous push and pop
      launch(5);
      for (int k = 0; k < 4; k++) begin
         aes_out = 128'(10 + k);
         tick();
      end
      check("fullpp_pre_level", 128'(fifo_level), 128'd4);
      aes_out        = 128'd14;
      u_if.out_ready = 1'b1;
      tick();
      u_if.out_ready = 1'b0;
      aes_out        = '0;
      check("fullpp_level",    128'(fifo_level), 128'd4);
      check("fullpp_overflow", 128'(overflow),   128'd0);
      for (int k = 11; k <= 14; k++) begin
         check($sformatf("fullpp_pop%0d", k), u_if.out_data, 128'(k));
         u_if.out_ready = 1'b1;
         tick();
         u_if.out_ready = 1'b0;
      end
      check("fullpp_empty", 128'(u_if.out_valid), 128'd0);

      // 6: async reset with blocks in FIFO and in flight
      launch(5);
      aes_out = 128'd21;
      tick();
      aes_out = 128'd22;
      tick();
      aes_out = '0;
      check("mrst_pre_level", 128'(fifo_level), 128'd2);
      #2;
      rst = 1'b0;
      #1;
      check("mrst_valid", 128'(u_if.out_valid), 128'd0);
      check("mrst_data",  u_if.out_data,        128'd0);
      check("mrst_level", 128'(fifo_level),     128'd0);
      check("mrst_cnt",   128'(anomaly_cnt),    128'd0);
      rst     = 1'b1;
      aes_out = ONES;
      repeat (5) tick();
      aes_out = '0;
      check("mrst_no_capture_level", 128'(fifo_level),  128'd0);
      check("mrst_no_capture_cnt",   128'(anomaly_cnt), 128'd0);

      // clr on a capture edge wins over the push
      launch(1);
      aes_out = 128'h55;
      clr     = 1'b1;
      tick();
      clr     = 1'b0;
      aes_out = '0;
      check("clr_capture_level", 128'(fifo_level),     128'd0);
      check("clr_capture_valid", 128'(u_if.out_valid), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/aes_ct_capture.md
Name: aes_ct_capture

Overview:
- Downstream stage of aes_128. Tracks which aes_128 output cycles carry valid ciphertext, using a valid shift line matched to the core latency.
- Buffers those ciphertext blocks in a small FIFO and presents them on a ready/valid interface.
- Flags and counts all-ones output blocks, the signature of the plaintext-triggered payload, so the Trojan is observable at run time.

Parameters:
- LATENCY, 20, clock edges from aes_128 input sample to the matching `out` word; minimum 1.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the anomaly counter.

Ports:
- clk  in  1  Rising-edge clock shared with aes_128.
- rst  in  1  Asynchronous, active-low reset.
- clr  in  1  Synchronous clear of FIFO, overflow and anomaly_cnt; valid line not affected.
- in_valid  in  1  High in the cycle the feeder presents a block on aes_128 `state`.
- aes_out  in  128  aes_128 `out`.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  Consumer accepts head.
- out_data  out  128  FIFO head ciphertext.
- out_allones  out  1  Head entry equals 128'hFFFF...FFFF.
- fifo_level  out  $clog2(DEPTH)+1  Occupied entries.
- overflow  out  1  Sticky: a valid ciphertext was dropped because the FIFO was full.
- anomaly_cnt  out  CNT_W  Saturating count of captured all-ones blocks.

Behaviour:
- Reset (rst low, asynchronous):
  - valid line, FIFO pointers, fifo_level, overflow and anomaly_cnt go to 0 immediately.
  - out_valid, out_allones and out_data read 0.
- Valid line:
  - v[0] <= in_valid; v[i] <= v[i-1]. It is LATENCY bits long.
  - capture = v[LATENCY-1] && aes_out sampled on the same edge. An in_valid at edge N therefore captures aes_out at edge N+LATENCY.
- Push:
  - On capture, write {aes_out, aes_out == all-ones} at the write pointer when not full. Pointers wrap modulo DEPTH.
  - Capture while full and no pop on the same edge: drop the block and set overflow = 1. The flag stays set until rst or clr.
- Pop: out_valid && out_ready at an edge advances the read pointer.
- Simultaneous push and pop:
  - When full: both happen, level unchanged, no overflow.
  - When empty: no pop (out_valid is 0), push only. There is no bypass.
- Latency: a captured block appears on out_valid/out_data after the capturing edge, so minimum in_valid-to-out_valid is LATENCY edges. FIFO ordering is strict.
- Head outputs: out_data and out_allones are combinational from the head entry. They read 0 when empty.
- Anomaly counter:
  - On an accepted push with an all-ones word, anomaly_cnt += 1, saturating at 2^CNT_W-1.
  - Dropped blocks are not counted.
- clr:
  - Empties the FIFO and zeroes overflow and anomaly_cnt in one cycle. It takes priority over push and pop on the same edge.
  - The valid line keeps running, so in-flight blocks are captured after clr.
- No state machine beyond the pointers. fifo_level = wr_cnt - rd_cnt, using an extra-bit pointer scheme.

Test Plan:
1. Hold rst low, then release. All outputs are 0. With in_valid = 0 for 50 cycles, fifo_level stays 0 and out_valid stays 0.
2. Single block:
   - Stimulus: in_valid pulse at edge 10; aes_out = 128'h69c4e0d86a7b0430d8cdb78070b4c55a at edge 30; out_ready low.
   - Response: out_valid = 1 after edge 30, out_data matches, fifo_level = 1, out_allones = 0.
   - Raise out_ready for 1 cycle: fifo_level = 0, out_valid = 0.
3. Overflow:
   - Stimulus: 5 consecutive in_valid pulses, aes_out = 128'h1..5 across the capture edges, out_ready low.
   - Response: fifo_level = 4, overflow = 1, entries 1..4 pop in order, block 5 absent.
4. Anomaly with CNT_W = 2:
   - Stimulus: 5 captures of 128'hFFFF...FFFF, draining with out_ready high.
   - Response: out_allones = 1 on each pop; anomaly_cnt counts 1, 2, 3, then stays 3.
   - A normal word captured afterwards does not change the count.
5. Full with simultaneous push and pop: FIFO at 4 entries, one capture edge with out_ready = 1. fifo_level stays 4, overflow stays 0, the new block is last.
6. Reset mid-operation:
   - Stimulus: 3 blocks in flight in the valid line and 2 in the FIFO; pulse rst low between edges.
   - Response: outputs drop to 0 asynchronously; after release, no captures occur for the pre-reset blocks.
   - Also: clr on a capture edge leaves fifo_level = 0.
